// File: rtl/sync_fifo_dp.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_dp
// Description : Single-clock FIFO on an inferred dual-port RAM (WD x 2**AD).
//               Wrap-bit pointers, occupancy count, full/empty,
//               almost-full/almost-empty thresholds, overflow/underflow
//               pulses and a registered read port with a valid strobe.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous reset, active low
//               wr_en / din  - write request and data
//               rd_en        - read request
//               dout         - registered read data (holds when idle)
//               dout_vld     - one-cycle strobe for a newly popped word
//               full, empty, almost_full, almost_empty, count
//               overflow     - pulse: write attempted while full
//               underflow    - pulse: read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_dp #(
    parameter int WD     = 8,
    parameter int AD     = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] din,
    input  logic          rd_en,
    output logic [WD-1:0] dout,
    output logic          dout_vld,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AD:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int          c_DEPTH   = 1 << AD;
    localparam logic [AD:0] c_ONE     = {{AD{1'b0}}, 1'b1};
    localparam logic [AD:0] c_AF_LVL  = AF_LVL[AD:0];
    localparam logic [AD:0] c_AE_LVL  = AE_LVL[AD:0];

    // Threshold parameters outside their legal range are rejected at elaboration.
    if ((AF_LVL < 1) || (AF_LVL > c_DEPTH) || (AE_LVL < 0) || (AE_LVL >= c_DEPTH)) begin : g_param_err
        $error("sync_fifo_dp: AF_LVL/AE_LVL out of range");
    end

    logic [WD-1:0] r_mem [c_DEPTH];

    logic [AD:0]   r_wr_ptr;
    logic [AD:0]   r_rd_ptr;
    logic [AD:0]   r_count;
    logic [WD-1:0] r_dout;
    logic          r_dout_vld;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AD:0]   w_wr_ptr_nxt;
    logic [AD:0]   w_rd_ptr_nxt;
    logic [AD:0]   w_count_nxt;

    // Acceptance looks only at the registered flags, so a simultaneous
    // read cannot make room for a write in the same cycle (and vice versa).
    assign w_wr_acc     = wr_en & ~r_full;
    assign w_rd_acc     = rd_en & ~r_empty;
    assign w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + c_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + c_ONE) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // RAM array: contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AD-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_dout         <= '0;
            r_dout_vld     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_dout_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr[AD-1:0]];
            end
            // Same low index with differing wrap bits means the writer is a
            // full lap ahead of the reader.
            r_full         <= (w_wr_ptr_nxt[AD-1:0] == w_rd_ptr_nxt[AD-1:0]) &&
                              (w_wr_ptr_nxt[AD] != w_rd_ptr_nxt[AD]);
            r_empty        <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_almost_full  <= (w_count_nxt >= c_AF_LVL);
            r_almost_empty <= (w_count_nxt <= c_AE_LVL);
            r_overflow     <= wr_en & r_full;
            r_underflow    <= rd_en & r_empty;
        end
    end

    assign dout         = r_dout;
    assign dout_vld     = r_dout_vld;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_dp
// Description : Directed self-checking bench for sync_fifo_dp (WD=8, AD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_dp;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_vld;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    sync_fifo_dp #(
        .WD    (8),
        .AD    (4),
        .AF_LVL(12),
        .AE_LVL(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_empty",  32'(empty),        32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full",   32'(full),         32'd0);
        chk("rst_afull",  32'(almost_full),  32'd0);
        chk("rst_count",  32'(count),        32'd0);
        chk("rst_dout",   32'(dout),         32'd0);
        chk("rst_vld",    32'(dout_vld),     32'd0);
        chk("rst_ovf",    32'(overflow),     32'd0);
        chk("rst_udf",    32'(underflow),    32'd0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("fill_count",  32'(count),        32'(i + 1));
            chk("fill_afull",  32'(almost_full),  32'((i + 1) >= 12));
            chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
            chk("fill_full",   32'(full),         32'((i + 1) == 16));
            chk("fill_empty",  32'(empty),        32'd0);
        end
        cyc(1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd16);
        chk("ovf_full",  32'(full),     32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Drain: expect 0x00..0x0F, the dropped 0xFF never appears
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_dout",  32'(dout),     32'(i));
            chk("drain_vld",   32'(dout_vld), 32'd1);
            chk("drain_count", 32'(count),    32'(15 - i));
            chk("drain_empty", 32'(empty),    32'(i == 15));
            chk("drain_full",  32'(full),     32'd0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_dout",  32'(dout),      32'h0F);
        chk("udf_vld",   32'(dout_vld),  32'd0);
        chk("udf_count", 32'(count),     32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(underflow), 32'd0);
        chk("idle_vld",  32'(dout_vld),  32'd0);

        // Wrap: second batch spans RAM index 15 -> 0
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("wrap1_dout", 32'(dout), 32'(8'h50 + i));
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
        chk("wrap_count", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("wrap2_dout", 32'(dout),     32'(8'hA0 + i));
            chk("wrap2_vld",  32'(dout_vld), 32'd1);
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous read/write at count=5
        q.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h30 + i), 1'b0);
            q.push_back(8'(8'h30 + i));
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = q.pop_front();
            q.push_back(8'(8'h40 + i));
            cyc(1'b1, 8'(8'h40 + i), 1'b1);
            chk("sim_dout",  32'(dout),     32'(exp_d));
            chk("sim_vld",   32'(dout_vld), 32'd1);
            chk("sim_count", 32'(count),    32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            exp_d = q.pop_front();
            cyc(1'b0, 8'h00, 1'b1);
            chk("sim_drain", 32'(dout), 32'(exp_d));
        end
        chk("sim_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: write taken, read dropped
        cyc(1'b1, 8'h77, 1'b1);
        chk("se_udf",   32'(underflow), 32'd1);
        chk("se_count", 32'(count),     32'd1);
        chk("se_vld",   32'(dout_vld),  32'd0);
        chk("se_empty", 32'(empty),     32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("se_dout",  32'(dout),      32'h77);

        // Simultaneous at full: read taken, write dropped
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        chk("sf_full0", 32'(full), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("sf_ovf",   32'(overflow), 32'd1);
        chk("sf_count", 32'(count),    32'd15);
        chk("sf_dout",  32'(dout),     32'h80);
        chk("sf_vld",   32'(dout_vld), 32'd1);
        chk("sf_full",  32'(full),     32'd0);
        chk("sf_afull", 32'(almost_full), 32'd1);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("sf_drain", 32'(dout), 32'(8'h80 + i));
        end
        chk("sf_empty", 32'(empty), 32'd1);

        // Async reset mid-stream at count=7
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("ar_pre_count", 32'(count), 32'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_count",  32'(count),        32'd0);
        chk("ar_empty",  32'(empty),        32'd1);
        chk("ar_aempty", 32'(almost_empty), 32'd1);
        chk("ar_dout",   32'(dout),         32'd0);
        chk("ar_vld",    32'(dout_vld),     32'd0);
        #2;
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0);
        chk("ar_wcount", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("ar_rdout",  32'(dout),     32'h5A);
        chk("ar_rvld",   32'(dout_vld), 32'd1);
        chk("ar_rempty", 32'(empty),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
